// File: rtl/ad_spi_pkg.sv
// Shared constants, types and channel-sequencing helper for the ADC SPI responder.
package ad_spi_pkg;

  localparam logic [15:0] CMD_NO_OP    = 16'h0000;
  localparam logic [15:0] CMD_AUTO_RST = 16'hA000;
  localparam logic [15:0] CMD_MAN_CH   = 16'hC000;
  localparam logic [15:0] CMD_MAN_STEP = 16'h0400;
  localparam logic [15:0] CMD_RST      = 16'h8500;

  localparam logic [6:0] REG_AUTO_SEQ = 7'h01;
  localparam logic [6:0] REG_PWR_DN   = 7'h02;
  localparam logic [6:0] REG_RANGE0   = 7'h05;
  localparam logic [6:0] REG_RANGE1   = 7'h06;
  localparam logic [6:0] REG_RANGE2   = 7'h07;
  localparam logic [6:0] REG_RANGE3   = 7'h08;

  localparam logic [7:0] RST_AUTO_SEQ = 8'hFF;
  localparam logic [7:0] RST_PWR_DN   = 8'h00;
  localparam logic [7:0] RST_RANGE    = 8'h00;

  typedef enum logic {MODE_MAN = 1'b0, MODE_AUTO = 1'b1} mode_e;
  typedef enum logic {ST_IDLE = 1'b0, ST_FRAME = 1'b1} frame_e;

  typedef struct packed {
    logic [7:0]      auto_seq;
    logic [7:0]      pwr_dn;
    logic [3:0][7:0] rng;
  } regs_t;

  localparam regs_t REGS_RST = '{auto_seq: RST_AUTO_SEQ, pwr_dn: RST_PWR_DN,
                                 rng: {4{RST_RANGE}}};

  // First channel set in mask at or after start, wrapping 3->0; 0 for an empty mask.
  function automatic logic [1:0] auto_next(input logic [3:0] mask, input logic [1:0] start);
    logic [1:0] r, c;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      c = start + 2'(i);
      if (mask[c]) r = c;
    end
    return r;
  endfunction

  function automatic logic [7:0] reg_rd(input regs_t r, input logic [6:0] a);
    case (a)
      REG_AUTO_SEQ: return r.auto_seq;
      REG_PWR_DN:   return r.pwr_dn;
      REG_RANGE0:   return r.rng[0];
      REG_RANGE1:   return r.rng[1];
      REG_RANGE2:   return r.rng[2];
      REG_RANGE3:   return r.rng[3];
      default:      return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/ad_spi_responder_if.sv
// SPI pin bundle between the ADC command master and the responder.
interface ad_spi_responder_if;
  logic SPI_CS;
  logic SPI_SCLK;
  logic SPI_MOSI;
  logic SPI_MISO;

  modport master (output SPI_CS, SPI_SCLK, SPI_MOSI, input SPI_MISO);
  modport slave  (input SPI_CS, SPI_SCLK, SPI_MOSI, output SPI_MISO);
endinterface

// File: rtl/ad_spi_sync_edge.sv
// 2-flop synchronizer plus one history flop for registered-input edge pulses.
module ad_spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [2:0] sr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr_q <= {3{RST_VAL}};
    else     sr_q <= {sr_q[1:0], d_i};
  end

  assign q_o    = sr_q[1];
  assign rise_o =  sr_q[1] & ~sr_q[2];
  assign fall_o = ~sr_q[1] &  sr_q[2];

endmodule

// File: rtl/ad_spi_responder.sv
// SPI slave model of a 4-channel 16-bit SAR ADC: command decode, program registers,
// channel sequencing and pipelined conversion readback from a parallel sample bus.
module ad_spi_responder
  import ad_spi_pkg::*;
#(
  parameter int CLK_RATIO_MIN = 8
) (
  input  logic                 clk,
  input  logic                 RESET,
  ad_spi_responder_if.slave    spi,
  input  logic [63:0]          ch_data,
  output logic                 sample_strobe,
  output logic [1:0]           sample_ch,
  output logic [15:0]          ch_range,
  output logic                 cmd_valid,
  output logic [15:0]          cmd_word,
  output logic [15:0]          frame_cnt
);

  if (CLK_RATIO_MIN < 6) begin : g_ratio_chk
    $error("CLK_RATIO_MIN below the 3-clk MISO turnaround");
  end

  logic cs_lvl, cs_rise, cs_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic mosi, mosi_rise, mosi_fall;

  // CS synchronizer resets low so that a reset taken mid-frame never fakes a CS fall.
  ad_spi_sync_edge #(.RST_VAL(1'b0)) u_cs (
    .clk(clk), .rst(RESET), .d_i(spi.SPI_CS),
    .q_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall));
  ad_spi_sync_edge #(.RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst(RESET), .d_i(spi.SPI_SCLK),
    .q_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall));
  ad_spi_sync_edge #(.RST_VAL(1'b0)) u_mosi (
    .clk(clk), .rst(RESET), .d_i(spi.SPI_MOSI),
    .q_o(mosi), .rise_o(mosi_rise), .fall_o(mosi_fall));

  logic unused_sync;
  assign unused_sync = ^{cs_lvl, sclk_lvl, sclk_rise, mosi_rise, mosi_fall};

  frame_e      st_q, st_d;
  mode_e       mode_q, mode_d;
  regs_t       regs_q, regs_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] cmd_sr_q, cmd_sr_d;
  logic [15:0] resp_sr_q, resp_sr_d;
  logic        miso_q, miso_d;
  logic [15:0] conv_q, conv_d;
  logic [1:0]  sel_q, sel_d;
  logic        strobe_q, strobe_d;
  logic [1:0]  sample_ch_q, sample_ch_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic [15:0] cmd_word_q, cmd_word_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  logic        active;
  logic [5:0]  cnt, cnt_n;
  logic [15:0] c, resp;

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      st_q        <= ST_IDLE;
      mode_q      <= MODE_MAN;
      regs_q      <= REGS_RST;
      bit_cnt_q   <= '0;
      cmd_sr_q    <= '0;
      resp_sr_q   <= '0;
      miso_q      <= 1'b0;
      conv_q      <= '0;
      sel_q       <= '0;
      strobe_q    <= 1'b0;
      sample_ch_q <= '0;
      cmd_valid_q <= 1'b0;
      cmd_word_q  <= '0;
      frame_cnt_q <= '0;
    end else begin
      st_q        <= st_d;
      mode_q      <= mode_d;
      regs_q      <= regs_d;
      bit_cnt_q   <= bit_cnt_d;
      cmd_sr_q    <= cmd_sr_d;
      resp_sr_q   <= resp_sr_d;
      miso_q      <= miso_d;
      conv_q      <= conv_d;
      sel_q       <= sel_d;
      strobe_q    <= strobe_d;
      sample_ch_q <= sample_ch_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_word_q  <= cmd_word_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_comb begin
    st_d        = st_q;
    mode_d      = mode_q;
    regs_d      = regs_q;
    bit_cnt_d   = bit_cnt_q;
    cmd_sr_d    = cmd_sr_q;
    resp_sr_d   = resp_sr_q;
    miso_d      = miso_q;
    conv_d      = conv_q;
    sel_d       = sel_q;
    strobe_d    = 1'b0;
    sample_ch_d = sample_ch_q;
    cmd_valid_d = 1'b0;
    cmd_word_d  = cmd_word_q;
    frame_cnt_d = frame_cnt_q;
    active      = (st_q == ST_FRAME);
    cnt         = bit_cnt_q;
    cnt_n       = bit_cnt_q + 6'd1;
    c           = {cmd_sr_q[14:0], mosi};
    resp        = conv_q;

    // CS fall is handled first so a coincident SCLK fall becomes bit 1 of the new frame.
    if (cs_fall) begin
      st_d        = ST_FRAME;
      active      = 1'b1;
      cnt         = '0;
      cnt_n       = 6'd1;
      bit_cnt_d   = '0;
      conv_d      = ch_data[{sel_q, 4'b0000} +: 16];
      strobe_d    = 1'b1;
      sample_ch_d = sel_q;
    end else if (cs_rise && active) begin
      st_d   = ST_IDLE;
      active = 1'b0;
      miso_d = 1'b0;
      if (bit_cnt_q >= 6'd16) frame_cnt_d = frame_cnt_q + 16'd1;
    end

    if (sclk_fall && active && cnt < 6'd32) begin
      bit_cnt_d = cnt_n;
      if (cnt_n <= 6'd16) cmd_sr_d = c;
      if (cnt_n == 6'd16) begin
        cmd_word_d  = c;
        cmd_valid_d = 1'b1;
        if (c == CMD_NO_OP) begin
          if (mode_q == MODE_AUTO) sel_d = auto_next(regs_q.auto_seq[3:0], sel_q + 2'd1);
        end else if (!c[15]) begin
          if (c[8]) begin
            resp = {c[7:0], 8'h00};
            case (c[15:9])
              REG_AUTO_SEQ: regs_d.auto_seq = c[7:0];
              REG_PWR_DN:   regs_d.pwr_dn   = c[7:0];
              REG_RANGE0:   regs_d.rng[0]   = c[7:0];
              REG_RANGE1:   regs_d.rng[1]   = c[7:0];
              REG_RANGE2:   regs_d.rng[2]   = c[7:0];
              REG_RANGE3:   regs_d.rng[3]   = c[7:0];
              default: ;
            endcase
          end else begin
            resp = {reg_rd(regs_q, c[15:9]), 8'h00};
          end
        end else if (c == CMD_RST) begin
          regs_d = REGS_RST;
          mode_d = MODE_MAN;
          sel_d  = 2'd0;
          resp   = 16'h0000;
        end else if (c == CMD_AUTO_RST) begin
          mode_d = MODE_AUTO;
          sel_d  = auto_next(regs_q.auto_seq[3:0], 2'd0);
        end else if (c[15:12] == CMD_MAN_CH[15:12] && c[9:0] == 10'd0) begin
          mode_d = MODE_MAN;
          sel_d  = c[11:10];
        end
        resp_sr_d = resp;
        miso_d    = resp[15];
      end else if (cnt_n > 6'd16) begin
        resp_sr_d = {resp_sr_q[14:0], 1'b0};
        miso_d    = (cnt_n == 6'd32) ? 1'b0 : resp_sr_q[14];
      end
    end
  end

  assign spi.SPI_MISO  = miso_q;
  assign sample_strobe = strobe_q;
  assign sample_ch     = sample_ch_q;
  assign ch_range      = {regs_q.rng[3][3:0], regs_q.rng[2][3:0],
                          regs_q.rng[1][3:0], regs_q.rng[0][3:0]};
  assign cmd_valid     = cmd_valid_q;
  assign cmd_word      = cmd_word_q;
  assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_ad_spi_responder.sv
// Directed + randomized SPI frames against a command-level model of the ADC responder.
module tb_ad_spi_responder;

  localparam int HALF = 4;

  logic        clk = 1'b0;
  logic        RESET;
  logic [63:0] ch_data;
  logic        sample_strobe;
  logic [1:0]  sample_ch;
  logic [15:0] ch_range;
  logic        cmd_valid;
  logic [15:0] cmd_word;
  logic [15:0] frame_cnt;

  ad_spi_responder_if spi ();

  ad_spi_responder #(.CLK_RATIO_MIN(8)) dut (
    .clk(clk), .RESET(RESET), .spi(spi), .ch_data(ch_data),
    .sample_strobe(sample_strobe), .sample_ch(sample_ch), .ch_range(ch_range),
    .cmd_valid(cmd_valid), .cmd_word(cmd_word), .frame_cnt(frame_cnt));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int       cv_cnt = 0;
  int       ss_cnt = 0;
  logic [1:0] ss_ch = 2'd0;
  always @(negedge clk) begin
    if (cmd_valid) cv_cnt++;
    if (sample_strobe) begin
      ss_cnt++;
      ss_ch = sample_ch;
    end
  end

  // Command-level model state
  logic [7:0]  m_reg [0:63];
  bit          m_auto;
  int          m_sel;
  logic [15:0] m_conv;
  int          m_fc;

  task automatic check(input string tag, input string what, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s/%s: observed %0h expected %0h", tag, what, obs, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic m_reset_regs();
    for (int i = 0; i < 64; i++) m_reg[i] = 8'h00;
    m_reg[1] = 8'hFF;
    m_auto   = 0;
    m_sel    = 0;
  endtask

  task automatic m_reset_all();
    m_reset_regs();
    m_conv = 16'h0;
    m_fc   = 0;
  endtask

  function automatic int m_lowest();
    for (int ch = 0; ch < 4; ch++) if (m_reg[1][ch]) return ch;
    return 0;
  endfunction

  function automatic int m_after(input int cur);
    for (int k = 1; k <= 4; k++) if (m_reg[1][(cur + k) % 4]) return (cur + k) % 4;
    return 0;
  endfunction

  function automatic logic [15:0] m_range();
    return {m_reg[8][3:0], m_reg[7][3:0], m_reg[6][3:0], m_reg[5][3:0]};
  endfunction

  task automatic model_cmd(input logic [15:0] cw, output logic [15:0] r);
    int a;
    r = m_conv;
    if (cw == 16'h0000) begin
      if (m_auto) m_sel = m_after(m_sel);
    end else if (cw[15] == 1'b0) begin
      a = int'(cw[14:9]);
      if (cw[8]) begin
        if (a inside {1, 2, 5, 6, 7, 8}) m_reg[a] = cw[7:0];
        r = {cw[7:0], 8'h00};
      end else begin
        r = {m_reg[a], 8'h00};
      end
    end else if (cw == 16'h8500) begin
      m_reset_regs();
      r = 16'h0000;
    end else if (cw == 16'hA000) begin
      m_auto = 1;
      m_sel  = m_lowest();
    end else if (cw inside {16'hC000, 16'hC400, 16'hC800, 16'hCC00}) begin
      m_auto = 0;
      m_sel  = int'((cw - 16'hC000) / 16'h0400);
    end
  endtask

  // Drives one frame; master samples MISO on SCLK rising edges 17..32.
  task automatic spi_frame(input logic [15:0] cmd, input int nbits, input int rst_at,
                           output logic [15:0] resp);
    resp = 16'h0;
    spi.SPI_CS = 1'b0;
    wclk(4);
    for (int i = 0; i < nbits; i++) begin
      spi.SPI_MOSI = (i < 16) ? cmd[15-i] : 1'b0;
      wclk(1);
      spi.SPI_SCLK = 1'b1;
      if (i >= 16) resp = {resp[14:0], spi.SPI_MISO};
      wclk(HALF);
      spi.SPI_SCLK = 1'b0;
      wclk(HALF);
      if (i == rst_at) begin
        RESET = 1'b1;
        wclk(1);
        check("midrst", "miso", 32'(spi.SPI_MISO), 0);
        check("midrst", "sample_ch", 32'(sample_ch), 0);
        check("midrst", "ch_range", 32'(ch_range), 0);
        check("midrst", "cmd_word", 32'(cmd_word), 0);
        check("midrst", "frame_cnt", 32'(frame_cnt), 0);
        check("midrst", "cmd_valid", 32'(cmd_valid), 0);
        RESET = 1'b0;
        m_reset_all();
      end
    end
    wclk(HALF);
    spi.SPI_CS = 1'b1;
    wclk(8);
  endtask

  task automatic run_frame(input string tag, input logic [15:0] cmd, input int nbits,
                           output logic [15:0] resp);
    int cv0, ss0, exp_sch;
    logic [15:0] exp_resp;
    ch_data = {$urandom, $urandom};
    cv0 = cv_cnt;
    ss0 = ss_cnt;
    exp_sch = m_sel;
    m_conv  = ch_data[m_sel*16 +: 16];
    spi_frame(cmd, nbits, -1, resp);
    check(tag, "strobes", ss_cnt - ss0, 1);
    check(tag, "sample_ch", 32'(ss_ch), exp_sch);
    if (nbits >= 16) begin
      model_cmd(cmd, exp_resp);
      m_fc++;
      check(tag, "cmd_valid", cv_cnt - cv0, 1);
      check(tag, "cmd_word", 32'(cmd_word), 32'(cmd));
      if (nbits == 32) check(tag, "resp", 32'(resp), 32'(exp_resp));
    end else begin
      check(tag, "no_cmd_valid", cv_cnt - cv0, 0);
    end
    check(tag, "frame_cnt", 32'(frame_cnt), m_fc & 32'hFFFF);
    check(tag, "ch_range", 32'(ch_range), 32'(m_range()));
    check(tag, "miso_idle", 32'(spi.SPI_MISO), 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] r;
    logic [15:0] cw;
    int k, a;
    spi.SPI_CS   = 1'b1;
    spi.SPI_SCLK = 1'b0;
    spi.SPI_MOSI = 1'b0;
    ch_data      = '0;
    RESET        = 1'b1;
    m_reset_all();
    wclk(3);
    check("reset", "miso", 32'(spi.SPI_MISO), 0);
    check("reset", "strobe", 32'(sample_strobe), 0);
    check("reset", "sample_ch", 32'(sample_ch), 0);
    check("reset", "ch_range", 32'(ch_range), 0);
    check("reset", "cmd_valid", 32'(cmd_valid), 0);
    check("reset", "cmd_word", 32'(cmd_word), 0);
    check("reset", "frame_cnt", 32'(frame_cnt), 0);
    RESET = 1'b0;
    wclk(6);

    // Register write then read-back
    run_frame("wr05", 16'h0B06, 32, r);
    check("wr05", "range_lsn", 32'(ch_range[3:0]), 6);
    run_frame("rd05", 16'h0A00, 32, r);
    check("rd05", "resp_const", 32'(r), 32'h0600);

    // Manual channel select, pipelined one frame
    run_frame("man1a", 16'hC400, 32, r);
    run_frame("man1b", 16'hC400, 32, r);
    check("man1b", "ch1_data", 32'(r), 32'(ch_data[31:16]));
    check("man1b", "sample_ch1", 32'(ss_ch), 1);

    // Auto sequence over mask 0x05
    run_frame("mask05", 16'h0305, 32, r);
    run_frame("autorst", 16'hA000, 32, r);
    run_frame("noop1", 16'h0000, 32, r);
    check("noop1", "seq", 32'(ss_ch), 0);
    run_frame("noop2", 16'h0000, 32, r);
    check("noop2", "seq", 32'(ss_ch), 2);
    run_frame("noop3", 16'h0000, 32, r);
    check("noop3", "seq", 32'(ss_ch), 0);
    run_frame("after", 16'hC000, 32, r);
    check("after", "seq", 32'(ss_ch), 2);

    // Short frame is dropped, the following one decodes
    run_frame("short", 16'hC800, 10, r);
    run_frame("full", 16'hC800, 32, r);
    run_frame("full2", 16'h0000, 32, r);
    check("full2", "sample_ch2", 32'(ss_ch), 2);

    // Register reset command
    run_frame("wr06", 16'h0D03, 32, r);
    run_frame("wr08", 16'h110C, 32, r);
    run_frame("rst", 16'h8500, 32, r);
    check("rst", "ch_range_zero", 32'(ch_range), 0);
    run_frame("rd01", 16'h0200, 32, r);
    check("rd01", "resp_ff", 32'(r), 32'hFF00);

    // Randomized command mix
    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 7);
      case (k)
        0: begin
          a = $urandom_range(0, 9);
          if (a > 5) a = $urandom_range(0, 63);
          else a = (a < 2) ? a + 1 : a + 3;
          cw = {1'b0, 6'(a), 1'b1, 8'($urandom)};
        end
        1: cw = {1'b0, 6'($urandom_range(0, 63)), 1'b0, 8'($urandom)};
        2: cw = 16'hC000 + 16'($urandom_range(0, 3)) * 16'h0400;
        3: cw = 16'hA000;
        4, 5: cw = 16'h0000;
        6: cw = 16'h8500;
        default: cw = 16'h8000 | 16'($urandom);
      endcase
      run_frame("rand", cw, 32, r);
    end

    // Reset in the middle of a frame
    run_frame("pre_wr", 16'h0B0F, 32, r);
    ch_data = {$urandom, $urandom};
    spi_frame(16'hC400, 32, 19, r);
    check("postrst", "frame_cnt", 32'(frame_cnt), 0);
    check("postrst", "miso", 32'(spi.SPI_MISO), 0);
    run_frame("c800", 16'hC800, 32, r);
    check("c800", "sample_ch0", 32'(ss_ch), 0);
    check("c800", "frame_one", 32'(frame_cnt), 1);
    run_frame("c800n", 16'h0000, 32, r);
    check("c800n", "sample_ch2", 32'(ss_ch), 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ad_spi_responder.md
# ad_spi_responder

Synthesizable SPI slave that models the 4-channel 16-bit SAR ADC driven by the team's ADC command master. It receives 16-bit commands on the ADC serial bus, decodes program-register writes and reads, manual and auto channel selection, and register reset, and returns 16-bit conversion words taken from a parallel sample interface. It is used as the far end of the ADC link in system simulation and in loop-back hardware builds. It runs on a system clock that oversamples the SPI pins.

## Interface
- `CLK_RATIO_MIN`, default 8: minimum clk/SCLK frequency ratio the block is specified for. Documentation only; it is not used in logic.
- `clk` input 1: system clock. Every register in the block runs on the rising edge of clk.
- `RESET` input 1: asynchronous, active-high reset.
- `SPI_CS` input 1: chip select, active low, driven by the master.
- `SPI_SCLK` input 1: serial clock from the master. It idles low.
- `SPI_MOSI` input 1: command bits, MSB first.
- `SPI_MISO` output 1: response bits, MSB first. Reset value 0.
- `ch_data` input 64: conversion values. `[16n+15:16n]` holds channel n, for n = 0..3.
- `sample_strobe` output 1: one-cycle pulse marking a conversion start. Reset value 0.
- `sample_ch` output 2: channel being converted. Reset value 0.
- `ch_range` output 16: `{reg08[3:0], reg07[3:0], reg06[3:0], reg05[3:0]}`. Reset value 0.
- `cmd_valid` output 1: one-cycle pulse when a command has been received in full. Reset value 0.
- `cmd_word` output 16: the last complete command. Reset value 0.
- `frame_cnt` output 16: number of complete frames, wrapping at 0xFFFF. Reset value 0.

## Operation
Input conditioning and framing:
- `SPI_CS`, `SPI_SCLK` and `SPI_MOSI` each pass through a 2-flop synchronizer. Edge detection runs on the synchronized values.
- A frame opens when CS falls and closes when CS rises.
- `bit_cnt` (6 bits) counts SCLK falling edges within a frame.

Falling-edge events:
- CS falling:
  - The block latches `ch_data` for `sel_ch` into `conv_reg`.
  - It pulses `sample_strobe` and sets `sample_ch = sel_ch`.
  - It clears `bit_cnt`.
- SCLK falling, bits 1..16: `SPI_MOSI` is shifted into `cmd_sr`. This is the master's update-on-rising / sample-on-falling convention.
- 16th SCLK falling:
  - The command is decoded (see below).
  - `cmd_word` is loaded and `cmd_valid` pulses.
  - `resp_sr` is loaded with the response word and `SPI_MISO` drives `resp_sr[15]`.
- SCLK falling, bits 17..31: `resp_sr` shifts left and `SPI_MISO` drives the new MSB.
- After the 32nd SCLK falling, `SPI_MISO` is 0. Any extra SCLK edges are ignored.
- CS rising with `bit_cnt` ≥ 16: `frame_cnt` increments. `SPI_MISO` goes to 0.
- CS rising with `bit_cnt` < 16: the partial command is discarded. There is no decode and no state change.

Command decode (16-bit word c):
- c[15]=0 is a program-register access. addr = c[15:9], wr = c[8], data = c[7:0].
  - Implemented registers: 0x01 auto-sequence mask, reset value 0xFF. 0x02 power-down, reset value 0x00. 0x05..0x08 channel range, reset value 0x00.
  - Writes to any other address are ignored.
  - For a write, the response is `{data, 8'h00}`.
  - For a read, the response is `{reg[addr], 8'h00}`. Unimplemented addresses read as 0.
- 0xC000 / 0xC400 / 0xC800 / 0xCC00 (MAN_Ch_0..3): mode becomes MAN and `sel_ch` becomes the channel number. The response is `conv_reg`.
- 0xA000 (AUTO_RST): mode becomes AUTO. `sel_ch` becomes the lowest channel set in `reg01[3:0]`. The response is `conv_reg`.
- 0x0000 (NO_OP):
  - In AUTO, `sel_ch` advances to the next channel set in `reg01[3:0]`, wrapping 3→0.
  - In MAN, `sel_ch` is unchanged.
  - The response is `conv_reg`.
- 0x8500 (RST): registers return to reset values, mode becomes MAN and `sel_ch` becomes 0. The response is 0.
- Any other command: no state change. The response is `conv_reg`.
- If `reg01[3:0]` is 0, AUTO selects channel 0.

Pipeline rule: a selection made in frame N is converted at the CS fall of frame N+1 and returned in frame N+1.

Reset mid-frame: all state returns to reset values. The frame in progress is aborted, and the next CS fall starts a new frame.

## Timing
- Pin-to-event latency is 3 clk: 2 for synchronization, 1 for edge detection.
- `SPI_MISO` is valid at most 3 clk after an SCLK falling edge. This meets the next rising edge when the clk/SCLK ratio is at least `CLK_RATIO_MIN`.
- `cmd_valid` and `sample_strobe` last exactly 1 clk.
- `cmd_word`, the register file and `ch_range` update in the same clk as `cmd_valid`.
- A CS fall and an SCLK fall arriving in the same clk: the CS fall is processed first, then the SCLK fall counts as bit 1.

## Structure
- Package `ad_spi_pkg` holds:
  - Command constants: NO_OP 0x0000, AUTO_RST 0xA000, MAN_CH base 0xC000 with step 0x0400, RST 0x8500.
  - Register address constants.
  - Register reset values.
  - The mode enum {MAN, AUTO}.
- One sub-module, `ad_spi_sync_edge`: a 2-flop synchronizer with rise/fall pulse outputs. It is instantiated for CS, SCLK and MOSI.

## Test plan
- Write frame 0x0B06, then read frame 0x0A00: `ch_range[3:0]`=6 after the write, and the read response is 0x0600.
- Frames C400, then C400 with `ch_data` ch1=0x1234: the second frame returns 0x1234 and `sample_ch`=1.
- AUTO_RST with reg01=0x05, then NO_OP×3: sample channels are 0, 2, 0, 2 over successive frames.
- A 10-bit frame (CS rises early): no `cmd_valid` and `frame_cnt` unchanged. The next full frame decodes correctly.
- RST 0x8500 after range writes: `ch_range`=0, and reg01 reads back 0xFF.
- `RESET` asserted at bit 20 of a frame: `SPI_MISO`=0 and all outputs return to reset values. The next frame C800 is decoded normally.
